// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_e      : controller FSM state encodings (codes 5-7 are illegal)
//   BCD_MAX      : largest legal decade digit value
//   is_valid_bcd : true when a 4-bit digit holds a legal BCD value (0..9)
package bcd_timer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_valid_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade digit of a BCD down-counter chain.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   load          : overwrite the digit with load_val (wins over decrement)
//   load_val      : value to load (caller guarantees a legal BCD digit)
//   dec_en        : a decrement tick is happening this cycle
//   borrow_in     : all lower digits are 0 (tie high on digit 0)
//   digit         : current digit value
//   borrow_out    : combinational; digit is 0 and borrow_in is high
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en && borrow_in) begin
      digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = borrow_in && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Presettable BCD countdown timer controller.
// Validates and loads a BCD preset, sequences IDLE/ARMED/RUN/PAUSE/DONE, divides the clock
// into decrement ticks and flags terminal count.
// Parameters:
//   DIGITS   : number of BCD digits in the chain (1..8)
//   TICK_DIV : clock cycles per decrement tick while running (>=1)
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   preset_bcd   : BCD preset, digit 0 in bits [3:0]
//   load         : capture preset_bcd (single-cycle strobe)
//   start        : begin (from ARMED) or resume (from PAUSE) counting
//   pause        : freeze counting while running
//   clear        : synchronous abort to IDLE with count 0
//   count_bcd    : current BCD count
//   state        : FSM state code
//   running      : registered, high while state is RUN
//   done         : one-cycle pulse when the count reaches 0
//   err          : one-cycle pulse on a rejected (non-BCD) load
module bcd_countdown_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   preset_bcd,
  input  logic                  load,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [2:0]            state,
  output logic                  running,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, done_q, err_q;
  logic          done_d, err_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;

  logic          preset_ok;
  logic          preset_zero;
  logic          count_zero;
  logic          count_one;
  logic [DIGITS:0] borrow;

  // Preset validation: every digit must be 0..9.
  always_comb begin
    preset_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_valid_bcd(preset_bcd[4*i +: 4])) begin
        preset_ok = 1'b0;
      end
    end
  end

  assign preset_zero = (preset_bcd == '0);
  assign count_zero  = (count_bcd == '0);
  // The decremented value is zero exactly when the current count is 1.
  assign count_one   = (count_bcd == CW'(1));

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (clear) begin
      state_d  = StIdle;
      presc_d  = '0;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        StIdle, StArmed, StDone: begin
          if (load) begin
            if (!preset_ok) begin
              err_d = 1'b1;
            end else if (preset_zero) begin
              state_d  = StIdle;
              presc_d  = '0;
              cnt_load = 1'b1;
            end else begin
              state_d      = StArmed;
              presc_d      = '0;
              cnt_load     = 1'b1;
              cnt_load_val = preset_bcd;
            end
          end else if (start && (state_q == StArmed)) begin
            state_d = StRun;
            presc_d = '0;
          end
        end

        StRun: begin
          // Strict priority: a pending load or start masks pause even though both are no-ops
          // here, so counting simply continues.
          if (pause && !load && !start) begin
            state_d = StPause;
          end else if (presc_q == PrescLast) begin
            presc_d = '0;
            if (!count_zero) begin
              cnt_dec = 1'b1;
              if (count_one) begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        StPause: begin
          // Prescaler is retained across the pause.
          if (!load && start) begin
            state_d = StRun;
          end
        end

        default: begin
          state_d  = StIdle;
          presc_d  = '0;
          cnt_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= (state_d == StRun);
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Digit chain: digit 0 always sees a borrow; digit i sees one when all lower digits are 0.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit_down u_digit (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .load_val   (cnt_load_val[4*g +: 4]),
      .dec_en     (cnt_dec),
      .borrow_in  (borrow[g]),
      .digit      (count_bcd[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  assign state   = state_q;
  assign running = running_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
module tb_bcd_countdown_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned TICK_DIV = 4;

  logic        clock;
  logic        reset;
  logic [15:0] preset_bcd;
  logic        load, start, pause, clear;
  logic [15:0] count_bcd;
  logic [2:0]  state;
  logic        running, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [21:0] exp;
  } exp_t;

  exp_t sb[$];

  bcd_countdown_ctrl #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .preset_bcd (preset_bcd),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .count_bcd  (count_bcd),
    .state      (state),
    .running    (running),
    .done       (done),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Push an expected snapshot {count, state, running, done, err}.
  task automatic push_exp(input string tag, input logic [15:0] c, input logic [2:0] s,
                          input logic r, input logic d, input logic e);
    exp_t x;
    x.tag = tag;
    x.exp = {c, s, r, d, e};
    sb.push_back(x);
  endtask

  task automatic check_pop();
    exp_t        x;
    logic [21:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    x   = sb.pop_front();
    obs = {count_bcd, state, running, done, err};
    assert (obs === x.exp) else begin
      errors++;
      $error("FAIL %s observed cnt=%h st=%0d run=%b done=%b err=%b expected cnt=%h st=%0d run=%b done=%b err=%b",
             x.tag, obs[21:6], obs[5:3], obs[2], obs[1], obs[0],
             x.exp[21:6], x.exp[5:3], x.exp[2], x.exp[1], x.exp[0]);
    end
  endtask

  // Drive a command for exactly one edge.
  task automatic cmd(input logic l, input logic st, input logic p, input logic c,
                     input logic [15:0] pre);
    load = l; start = st; pause = p; clear = c; preset_bcd = pre;
    step(1);
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; preset_bcd = '0;

    push_exp("reset_state", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(2);
    check_pop();
    reset = 1'b0;
    step(1);

    // Invalid preset rejected in IDLE.
    push_exp("bad_load_err", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h00A3);
    check_pop();
    push_exp("err_one_cycle", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_pop();
    push_exp("zero_load_idle", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_pop();

    // Basic countdown 0x0012 with TICK_DIV=4.
    push_exp("load_12_armed", 16'h0012, 3'd1, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h0012);
    check_pop();
    push_exp("start_run", 16'h0012, 3'd2, 1'b1, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_pop();
    push_exp("no_tick_yet", 16'h0012, 3'd2, 1'b1, 1'b0, 1'b0);
    step(3);
    check_pop();
    push_exp("first_tick", 16'h0011, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1);
    check_pop();
    push_exp("before_terminal", 16'h0001, 3'd2, 1'b1, 1'b0, 1'b0);
    step(43);
    check_pop();
    push_exp("terminal_done", 16'h0000, 3'd4, 1'b0, 1'b1, 1'b0);
    step(1);
    check_pop();
    push_exp("done_one_cycle", 16'h0000, 3'd4, 1'b0, 1'b0, 1'b0);
    step(1);
    check_pop();

    // Borrow chain.
    push_exp("load_100_from_done", 16'h0100, 3'd1, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
    check_pop();
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    push_exp("borrow_0099", 16'h0099, 3'd2, 1'b1, 1'b0, 1'b0);
    step(4);
    check_pop();
    push_exp("borrow_0098", 16'h0098, 3'd2, 1'b1, 1'b0, 1'b0);
    step(4);
    check_pop();
    push_exp("clear_in_run", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check_pop();
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    push_exp("borrow_0999", 16'h0999, 3'd2, 1'b1, 1'b0, 1'b0);
    step(4);
    check_pop();

    // Load ignored while running.
    push_exp("load_ignored_run", 16'h0999, 3'd2, 1'b1, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005);
    check_pop();
    push_exp("count_continues", 16'h0998, 3'd2, 1'b1, 1'b0, 1'b0);
    step(3);
    check_pop();

    // Pause on the tick-due cycle, resume two cycles later.
    step(3);
    push_exp("pause_suppresses_tick", 16'h0998, 3'd3, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_pop();
    push_exp("pause_holds", 16'h0998, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1);
    check_pop();
    push_exp("resume_run", 16'h0998, 3'd2, 1'b1, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_pop();
    push_exp("resume_immediate_tick", 16'h0997, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1);
    check_pop();

    // clear beats start in PAUSE.
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    push_exp("clear_over_start", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    check_pop();

    // Asynchronous reset mid-count.
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
    push_exp("run_count_3", 16'h0003, 3'd2, 1'b1, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_pop();
    step(2);
    push_exp("async_reset_now", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_pop();
    reset = 1'b0;
    step(1);
    push_exp("start_ignored_idle", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_pop();
    push_exp("still_idle_no_done", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(16);
    check_pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
